sha256_msg_padder: RTL and testbench

//  Upstream feeder for the ten-stage SHA-256 pipeline.
//  - Accepts a message as a stream of 32-bit big-endian words over valid/ready.
//  - Applies FIPS 180-4 padding: 0x80 marker, zero fill, 64-bit bit-length.
//  - Emits complete 512-bit blocks, plus a flag marking the final block of each message.

---
 rtl/sha256_pkg.sv | 20 ++
 rtl/sha256_pad_word.sv | 21 ++
 rtl/sha256_msg_padder.sv | 197 +++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 message front end.
package sha256_pkg;

    localparam int          BLOCK_WORDS = 16;
    localparam int          LEN_WORD_HI = 14;
    localparam int          LEN_WORD_LO = 15;
    localparam logic [31:0] PAD_MARKER  = 32'h8000_0000;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        EMIT  = 2'd1,
        EXTRA = 2'd2
    } pad_state_t;

    // Byte counts above four mean a full word.
    function automatic logic [2:0] clamp_bytes(input logic [2:0] bytes);
        clamp_bytes = (bytes > 3'd4) ? 3'd4 : bytes;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Final-word formatter: keeps the valid leading bytes, appends the 0x80 marker, zeroes the rest.
module sha256_pad_word
    import sha256_pkg::*;
(
    input  logic [31:0] data,
    input  logic [2:0]  bytes,
    output logic [31:0] word
);

    // Mask and mark the word; a full word has no room for the marker and passes through.
    always_comb begin
        case (clamp_bytes(bytes))
            3'd0:    word = PAD_MARKER;
            3'd1:    word = {data[31:24], 24'h80_0000};
            3'd2:    word = {data[31:16], 16'h8000};
            3'd3:    word = {data[31:8], 8'h80};
            default: word = data;
        endcase
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Streams 32-bit message words into padded 512-bit SHA-256 blocks.
// Define SHA256_PAD_STATS_EN to add the blk_count handshake counter output.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_bytes,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [511:0] blk_data,
    output logic         blk_last
`ifdef SHA256_PAD_STATS_EN
    ,
    output logic [31:0]  blk_count
`endif
);

    localparam int CNT_W = LEN_W - 3;

    pad_state_t     state_r;
    logic [3:0]     idx_r;
    logic [CNT_W-1:0] byte_len_r;
    logic [CNT_W-1:0] byte_len_nxt_s;
    logic           need_extra_r;
    logic           extra_mark_r;
    logic           in_ready_r;
    logic           blk_valid_r;
    logic           blk_last_r;
    logic [511:0]   blk_data_r;
    logic [511:0]   fill_data_s;
    logic [511:0]   extra_data_s;
    logic [2:0]     bytes_s;
    logic [2:0]     add_s;
    logic [4:0]     idx5_s;
    logic [4:0]     mark_idx_s;
    logic           mark_fits_s;
    logic [63:0]    len_now_s;
    logic [63:0]    len_reg_s;
    logic [31:0]    pad_word_s;
    logic           in_fire_s;
    logic           blk_fire_s;

    sha256_pad_word u_pad_word (
        .data  (in_data),
        .bytes (in_bytes),
        .word  (pad_word_s)
    );

    // Length bookkeeping and marker position for the word being offered.
    always_comb begin
        bytes_s        = clamp_bytes(in_bytes);
        add_s          = in_last ? bytes_s : 3'd4;
        byte_len_nxt_s = byte_len_r + CNT_W'(add_s);
        idx5_s         = {1'b0, idx_r};
        mark_idx_s     = idx5_s + ((bytes_s == 3'd4) ? 5'd1 : 5'd0);
        mark_fits_s    = (mark_idx_s < 5'(LEN_WORD_HI));
        len_now_s      = 64'({byte_len_nxt_s, 3'b000});
        len_reg_s      = 64'({byte_len_r, 3'b000});
        in_fire_s      = in_valid && in_ready_r;
        blk_fire_s     = blk_valid_r && blk_ready;
        extra_data_s   = {(extra_mark_r ? PAD_MARKER : 32'h0), 416'h0, len_reg_s};
    end

    for (genvar g = 0; g < BLOCK_WORDS; g++) begin : g_word
        localparam logic [4:0] G = 5'(g);
        logic [31:0] w_s;

        // Next value of buffer word g when a message word is accepted.
        always_comb begin
            if (G < idx5_s) begin
                w_s = blk_data_r[511-32*g -: 32];
            end else if (G == idx5_s) begin
                w_s = in_last ? pad_word_s : in_data;
            end else if (!in_last) begin
                w_s = blk_data_r[511-32*g -: 32];
            end else if (G == mark_idx_s) begin
                w_s = PAD_MARKER;
            end else if (mark_fits_s && (G == 5'(LEN_WORD_HI))) begin
                w_s = len_now_s[63:32];
            end else if (mark_fits_s && (G == 5'(LEN_WORD_LO))) begin
                w_s = len_now_s[31:0];
            end else begin
                w_s = 32'h0;
            end
        end

        assign fill_data_s[511-32*g -: 32] = w_s;
    end

    // Fill / emit / extra-block sequencing with registered handshake outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= FILL;
            idx_r        <= 4'd0;
            byte_len_r   <= '0;
            need_extra_r <= 1'b0;
            extra_mark_r <= 1'b0;
            in_ready_r   <= 1'b1;
            blk_valid_r  <= 1'b0;
            blk_last_r   <= 1'b0;
            blk_data_r   <= 512'h0;
        end else begin
            case (state_r)
                FILL: begin
                    if (in_fire_s) begin
                        blk_data_r <= fill_data_s;
                        byte_len_r <= byte_len_nxt_s;
                        if (in_last) begin
                            state_r      <= EMIT;
                            in_ready_r   <= 1'b0;
                            blk_valid_r  <= 1'b1;
                            idx_r        <= 4'd0;
                            blk_last_r   <= mark_fits_s;
                            need_extra_r <= !mark_fits_s;
                            extra_mark_r <= (mark_idx_s == 5'd16);
                        end else if (idx_r == 4'd15) begin
                            state_r      <= EMIT;
                            in_ready_r   <= 1'b0;
                            blk_valid_r  <= 1'b1;
                            idx_r        <= 4'd0;
                            blk_last_r   <= 1'b0;
                            need_extra_r <= 1'b0;
                            extra_mark_r <= 1'b0;
                        end else begin
                            idx_r <= idx_r + 4'd1;
                        end
                    end
                end
                EMIT: begin
                    if (blk_fire_s) begin
                        if (need_extra_r) begin
                            // The extra block is loaded on the handshake so valid never drops.
                            state_r      <= EXTRA;
                            blk_data_r   <= extra_data_s;
                            blk_last_r   <= 1'b1;
                            need_extra_r <= 1'b0;
                        end else begin
                            state_r     <= FILL;
                            in_ready_r  <= 1'b1;
                            blk_valid_r <= 1'b0;
                            blk_last_r  <= 1'b0;
                            if (blk_last_r) begin
                                byte_len_r <= '0;
                            end
                        end
                    end
                end
                EXTRA: begin
                    if (blk_fire_s) begin
                        state_r      <= FILL;
                        in_ready_r   <= 1'b1;
                        blk_valid_r  <= 1'b0;
                        blk_last_r   <= 1'b0;
                        extra_mark_r <= 1'b0;
                        byte_len_r   <= '0;
                    end
                end
                default: begin
                    state_r     <= FILL;
                    idx_r       <= 4'd0;
                    byte_len_r  <= '0;
                    in_ready_r  <= 1'b1;
                    blk_valid_r <= 1'b0;
                    blk_last_r  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SHA256_PAD_STATS_EN
    logic [31:0] blk_count_r;

    // Free-running count of block handshakes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_count_r <= 32'd0;
        end else if (blk_fire_s) begin
            blk_count_r <= blk_count_r + 32'd1;
        end
    end

    assign blk_count = blk_count_r;
`endif

    assign in_ready  = in_ready_r;
    assign blk_valid = blk_valid_r;
    assign blk_data  = blk_data_r;
    assign blk_last  = blk_last_r;

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder against a byte-level FIPS 180-4 padding model.
module tb_sha256_msg_padder;

    typedef struct packed {
        logic         last;
        logic [511:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_last;
    logic [2:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready = 1'b1;
    logic [511:0] blk_data;
    logic         blk_last;
`ifdef SHA256_PAD_STATS_EN
    logic [31:0]  blk_count;
`endif

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   hold_req    = 0;
    int   hold_seen   = 0;
    int   hold_left   = 0;
    bit   hold_arm    = 1'b0;
    bit   rand_ready  = 1'b0;
    bit   held        = 1'b0;
    logic [512:0] held_val;

    always #5 clk = ~clk;

    sha256_msg_padder dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
`ifdef SHA256_PAD_STATS_EN
        ,
        .blk_count (blk_count)
`endif
    );

    task automatic check(input string name, input logic [512:0] act, input logic [512:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: append 0x80, zero-fill to 56 mod 64, append 64-bit bit length, cut into blocks.
    function automatic void model_push(input logic [7:0] msg[$]);
        logic [7:0]  p[$];
        logic [63:0] bl;
        exp_t        e;
        int          nblk;
        p = msg;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        bl = 64'(msg.size()) * 64'd8;
        for (int k = 7; k >= 0; k--) p.push_back(bl[8*k +: 8]);
        nblk = p.size() / 64;
        for (int b = 0; b < nblk; b++) begin
            e.data = '0;
            for (int k = 0; k < 64; k++) e.data[511-8*k -: 8] = p[64*b+k];
            e.last = (b == nblk - 1);
            exp_q.push_back(e);
        end
    endfunction

    task automatic push_lit(input logic [511:0] data, input logic last);
        exp_t e;
        e.data = data;
        e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic drive_word(input logic [31:0] data, input logic last, input logic [2:0] nb);
        int cnt = 0;
        in_data  = data;
        in_last  = last;
        in_bytes = nb;
        in_valid = 1'b1;
        while (!in_ready && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        if (!in_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles, required 1", cnt);
        end else begin
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic send_msg(input logic [7:0] msg[$], input bit use_model, input bit gaps);
        int          len = msg.size();
        int          nw;
        int          rem;
        bit          trail;
        bit          last;
        logic [31:0] w;
        logic [2:0]  nb;
        if (use_model) model_push(msg);
        trail = (len > 0) && ((len % 4) == 0) && ($urandom_range(0, 3) == 0);
        nw = (len == 0) ? 1 : ((len + 3) / 4 + (trail ? 1 : 0));
        for (int i = 0; i < nw; i++) begin
            w = $urandom;
            for (int k = 0; k < 4; k++) begin
                if (4*i + k < len) w[31-8*k -: 8] = msg[4*i+k];
            end
            last = (i == nw - 1);
            rem  = len - 4*i;
            if (!last) nb = 3'($urandom_range(0, 7));
            else if (rem >= 4) nb = 3'($urandom_range(4, 7));
            else nb = 3'(rem);
            drive_word(w, last, nb);
            if (gaps && $urandom_range(0, 3) == 0) @(negedge clk);
        end
    endtask

    task automatic wait_drain();
        int cnt = 0;
        while ((exp_q.size() != 0 || blk_valid) && cnt < 3000) begin
            @(negedge clk);
            cnt++;
        end
        check("drain_pending", 513'(exp_q.size()), 513'd0);
    endtask

    // Monitor: drives blk_ready, checks hold behaviour and pops the scoreboard on each handshake.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            held      = 1'b0;
            hold_left = 0;
            hold_arm  = 1'b0;
            hold_seen = hold_req;
            blk_ready = 1'b1;
        end else begin
            if (hold_req != hold_seen) begin
                hold_seen = hold_req;
                hold_arm  = 1'b1;
            end
            if (hold_arm && blk_valid) begin
                hold_arm  = 1'b0;
                hold_left = 10;
            end
            if (hold_left > 0) begin
                blk_ready = 1'b0;
                hold_left--;
            end else if (rand_ready) begin
                blk_ready = ($urandom_range(0, 2) != 0);
            end else begin
                blk_ready = 1'b1;
            end
            if (blk_valid) begin
                check("in_ready_while_held", 513'(in_ready), 513'd0);
                if (held) check("blk_stable", {blk_last, blk_data}, held_val);
                if (blk_ready) begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_block: got blk_data=%h, required no block", blk_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("blk_data", 513'(blk_data), 513'(e.data));
                        check("blk_last", 513'(blk_last), 513'(e.last));
                    end
                end else begin
                    held     = 1'b1;
                    held_val = {blk_last, blk_data};
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        logic [7:0] m[$];
        logic [7:0] m2[$];
        int         cnt;
        int         len;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        in_last  = 1'b0;
        in_bytes = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_blk_valid", 513'(blk_valid), 513'd0);
        check("rst_blk_last", 513'(blk_last), 513'd0);
        check("rst_blk_data", 513'(blk_data), 513'd0);
        check("rst_in_ready", 513'(in_ready), 513'd1);
        reset = 1'b0;
        @(negedge clk);

        // "abc" and 56 bytes of 'A', then the stats count
        m = {8'h61, 8'h62, 8'h63};
        push_lit({32'h6162_6380, 448'h0, 32'h0000_0018}, 1'b1);
        send_msg(m, 1'b0, 1'b0);
        m = {};
        for (int i = 0; i < 56; i++) m.push_back(8'h41);
        send_msg(m, 1'b1, 1'b0);
        wait_drain();
`ifdef SHA256_PAD_STATS_EN
        check("blk_count", 513'(blk_count), 513'd3);
`endif

        // empty message, then 64 bytes (marker lands in an extra block)
        m = {};
        push_lit({32'h8000_0000, 480'h0}, 1'b1);
        send_msg(m, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) m.push_back(8'($urandom));
        send_msg(m, 1'b1, 1'b0);
        wait_drain();

        // backpressure held for 10 cycles with two messages back-to-back
        m = {};
        m2 = {};
        for (int i = 0; i < 60; i++) m.push_back(8'($urandom));
        for (int i = 0; i < 10; i++) m2.push_back(8'($urandom));
        hold_req++;
        send_msg(m, 1'b1, 1'b0);
        send_msg(m2, 1'b1, 1'b0);
        wait_drain();

        // reset after five words of a message, then "abc"
        for (int i = 0; i < 5; i++) drive_word($urandom, 1'b0, 3'd4);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("valid_in_reset", 513'(blk_valid), 513'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        m = {8'h61, 8'h62, 8'h63};
        push_lit({32'h6162_6380, 448'h0, 32'h0000_0018}, 1'b1);
        send_msg(m, 1'b0, 1'b0);
        wait_drain();

        // reset while a block is being held must drop blk_valid at once
        push_lit({32'h6162_6380, 448'h0, 32'h0000_0018}, 1'b1);
        hold_req++;
        send_msg(m, 1'b0, 1'b0);
        cnt = 0;
        while (!blk_valid && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        check("valid_before_reset", 513'(blk_valid), 513'd1);
        #2 reset = 1'b1;
        #1 check("valid_async_drop", 513'(blk_valid), 513'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // random lengths, boundary-heavy, with random gaps and backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 3))
                0:       len = 52 + int'($urandom_range(0, 13));
                1:       len = 116 + int'($urandom_range(0, 13));
                2:       len = int'($urandom_range(0, 8));
                default: len = int'($urandom_range(0, 200));
            endcase
            m = {};
            for (int i = 0; i < len; i++) m.push_back(8'($urandom));
            send_msg(m, 1'b1, 1'b1);
        end
        wait_drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
